seg_scan_ctrl: RTL

Time-multiplexed scan controller for the common-anode 7-segment display array driven by the DS1302 clock readout. Holds a frame of BCD digits in a shadow register, steps through digits one slot at a time, and presents each digit's code to the registered 7-segment decoder. Drives the active-low digit enables with a blanking gap, so the decoder's one-cycle output latency never shows ghost segments. Sits between the DS1302 read/BCD-unpack logic and the segment decoder/pins.

---
 rtl/seg_pkg.sv | 48 ++++
 rtl/scan_timer.sv | 92 +++++++++
 rtl/seg_scan_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared definitions for the 7-segment scan path: blank and
//                range codes for BCD digits, the slot state type, the
//                active-low segment patterns used by the segment decoder,
//                and small helper functions.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    // Nibble value that the display treats as "nothing to show".
    localparam logic [3:0] BLANK_CODE = 4'hF;
    // Largest nibble that is a displayable decimal digit.
    localparam logic [3:0] MAX_BCD    = 4'd9;

    // Slot phase: BLANK keeps every digit off while the decoder settles,
    // SHOW drives the enable of the current digit.
    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0   = 7'b100_0000;
    localparam logic [6:0] SEG_1   = 7'b111_1001;
    localparam logic [6:0] SEG_2   = 7'b010_0100;
    localparam logic [6:0] SEG_3   = 7'b011_0000;
    localparam logic [6:0] SEG_4   = 7'b001_1001;
    localparam logic [6:0] SEG_5   = 7'b001_0010;
    localparam logic [6:0] SEG_6   = 7'b000_0010;
    localparam logic [6:0] SEG_7   = 7'b111_1000;
    localparam logic [6:0] SEG_8   = 7'b000_0000;
    localparam logic [6:0] SEG_9   = 7'b001_0000;
    localparam logic [6:0] SEG_OFF = 7'b111_1111;

    // True when the nibble is a displayable decimal digit.
    function automatic logic is_bcd(input logic [3:0] code);
        return (code <= MAX_BCD);
    endfunction

    // Width of a digit index; a single-digit display still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : scan_timer
//  Description : Slot counter and digit index for the display scan, plus the
//                BLANK/SHOW slot phase. All status outputs are look-ahead:
//                they describe the cycle that follows the next clock edge,
//                so the caller can register its outputs and still line them
//                up with the counter.
//  Ports       : clk, rst_n     clock, async active-low reset
//                en             scan enable; low clears counter and index
//                slot_start     next cycle is cycle 0 of a slot
//                show           next cycle is in the SHOW phase
//                wrap           this edge wraps the slot counter
//                idx_nxt        digit index for the next cycle
//  Revision    : 1.0  initial release
// ============================================================================
module scan_timer
    import seg_pkg::*;
#(
    parameter  int NUM_DIGITS = 6,
    parameter  int SCAN_DIV   = 50000,
    parameter  int BLANK_CYC  = 500,
    localparam int IDX_W      = idx_width(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             slot_start,
    output logic             show,
    output logic             wrap,
    output logic [IDX_W-1:0] idx_nxt
);

    localparam int               CNT_W      = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    scan_state_e      state_q, state_d;

    // Counters
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        wrap  = 1'b0;
        if (!en) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            wrap  = 1'b1;
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State register and counter flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= BLANK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    // Next-state logic: SHOW starts once the blanking cycles are used up and
    // lasts until the slot wraps or the scan is disabled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   if (en && (cnt_q == BLANK_LAST)) state_d = SHOW;
            SHOW:    if (!en || wrap)                 state_d = BLANK;
            default:                                  state_d = BLANK;
        endcase
    end

    // Output logic
    always_comb begin
        slot_start = (cnt_d == '0);
        show       = (state_d == SHOW);
        idx_nxt    = idx_d;
    end

endmodule : scan_timer
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Time-multiplexed scan controller for a common-anode
//                7-segment array. Stages a frame of BCD digits, swaps it in
//                at the frame boundary, and walks the digits with a blanking
//                gap at the start of every slot so the registered decoder
//                downstream has settled before a digit is enabled.
//  Ports       : clk, rst_n     clock, async active-low reset
//                en             scan enable; low forces the display dark
//                load           strobe capturing digits_in / dp_in
//                digits_in      BCD digits, nibble i is digit i
//                dp_in          decimal-point request per digit
//                number_out     digit code for the segment decoder
//                dig_sel        active-low digit enables
//                dp_n           active-low decimal-point segment
//                frame_done     pulse in the first cycle of a new frame
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              number_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int                      IDX_W     = idx_width(NUM_DIGITS);
    localparam logic [4*NUM_DIGITS-1:0] BLANK_ALL = {NUM_DIGITS{BLANK_CODE}};

    logic [4*NUM_DIGITS-1:0] stage_q,    stage_d;
    logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d;
    logic [4*NUM_DIGITS-1:0] act_q,      act_d;
    logic [NUM_DIGITS-1:0]   act_dp_q,   act_dp_d;
    logic                    pending_q,  pending_d;
    logic [3:0]              number_out_q, number_out_d;
    logic [NUM_DIGITS-1:0]   dig_sel_q,    dig_sel_d;
    logic                    dp_n_q,       dp_n_d;
    logic                    frame_done_q, frame_done_d;

    logic             w_slot_start;
    logic             w_show;
    logic             w_wrap;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_boundary;
    logic [3:0]       w_code;
    logic             w_lit;

    scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC)
    ) u_scan_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .slot_start (w_slot_start),
        .show       (w_show),
        .wrap       (w_wrap),
        .idx_nxt    (w_idx_nxt)
    );

    // The last slot wrapping back to digit 0 marks the frame boundary.
    assign w_boundary = w_wrap && (w_idx_nxt == '0);

    // Frame buffers. A load on the boundary cycle itself goes straight to
    // the active frame so it is visible in the frame that starts now.
    always_comb begin
        stage_d    = stage_q;
        stage_dp_d = stage_dp_q;
        act_d      = act_q;
        act_dp_d   = act_dp_q;
        pending_d  = pending_q;
        if (load) begin
            stage_d    = digits_in;
            stage_dp_d = dp_in;
            pending_d  = 1'b1;
        end
        if (w_boundary) begin
            if (load) begin
                act_d     = digits_in;
                act_dp_d  = dp_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                act_d     = stage_q;
                act_dp_d  = stage_dp_q;
                pending_d = 1'b0;
            end
        end
    end

    // Outputs are computed from next-cycle counter and frame values so the
    // registered outputs line up with the counter they describe.
    assign w_code = act_d[{w_idx_nxt, 2'b00} +: 4];
    assign w_lit  = w_show && is_bcd(w_code);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig_sel
        assign dig_sel_d[gi] = ~(w_lit && (w_idx_nxt == IDX_W'(gi)));
    end

    always_comb begin
        number_out_d = w_code;
        dp_n_d       = ~(w_lit && act_dp_d[w_idx_nxt]);
        // cnt only returns to 0 with en high through a wrap.
        frame_done_d = en && w_slot_start && (w_idx_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q      <= BLANK_ALL;
            stage_dp_q   <= '0;
            act_q        <= BLANK_ALL;
            act_dp_q     <= '0;
            pending_q    <= 1'b0;
            number_out_q <= 4'h0;
            dig_sel_q    <= '1;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            stage_q      <= stage_d;
            stage_dp_q   <= stage_dp_d;
            act_q        <= act_d;
            act_dp_q     <= act_dp_d;
            pending_q    <= pending_d;
            number_out_q <= number_out_d;
            dig_sel_q    <= dig_sel_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign number_out = number_out_q;
    assign dig_sel    = dig_sel_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule : seg_scan_ctrl
`default_nettype wire
